// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Shares the register file's single write port among NUM_REQ
//            writeback requesters. It uses round-robin arbitration with a
//            valid/ready handshake and drives a registered write triple.
//            It also keeps a per-register pending-write scoreboard that
//            decode uses to stall on registers with outstanding writes.
// Ports    : clk_i           - clock, rising edge
//            rst_ni          - asynchronous active-low reset
//            req_valid_i     - per-requester write request
//            req_ready_o     - per-requester grant (combinational)
//            req_addr_i      - packed destination registers, ADDR_W each
//            req_data_i      - packed write data, DATA_W each
//            write_enable_o  - register-file write strobe (registered)
//            write_addr_o    - register-file write address (registered)
//            write_data_o    - register-file write data (registered)
//            claim_valid_i   - decode claims claim_addr_i as a destination
//            claim_addr_i    - register being claimed
//            flush_i         - synchronous scoreboard clear
//            busy_o          - per-register outstanding-write flag
//            err_overflow_o  - sticky: claim on a saturated counter
//            err_underflow_o - sticky: retire on a zero counter
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8,
  parameter int NUM_REQ  = 3,
  parameter int CNT_W    = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic                      write_enable_o,
  output logic [ADDR_W-1:0]         write_addr_o,
  output logic [DATA_W-1:0]         write_data_o,
  input  logic                      claim_valid_i,
  input  logic [ADDR_W-1:0]         claim_addr_i,
  input  logic                      flush_i,
  output logic [NUM_REGS-1:0]       busy_o,
  output logic                      err_overflow_o,
  output logic                      err_underflow_o
);

  localparam int                   c_PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [c_PTR_W-1:0]   c_LAST    = c_PTR_W'(NUM_REQ - 1);
  localparam logic [c_PTR_W:0]     c_NREQ    = (c_PTR_W + 1)'(NUM_REQ);
  localparam logic [CNT_W-1:0]     c_CNT_MAX = '1;

  // Arbitration state and output stage.
  logic [c_PTR_W-1:0] ptr_q, ptr_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               err_ovf_q, err_ovf_d;
  logic               err_unf_q, err_unf_d;

  logic               w_any;
  logic [c_PTR_W-1:0] w_win_idx;
  logic [c_PTR_W:0]   w_scan;
  logic [NUM_REQ-1:0] w_grant;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_data;
  logic [NUM_REGS-1:0] w_ovf;
  logic [NUM_REGS-1:0] w_unf;

  // Round-robin scan: visit ptr, ptr+1, ... (mod NUM_REQ) and take the first
  // valid requester. ptr < NUM_REQ and k < NUM_REQ, so one subtraction is
  // enough to wrap the sum.
  always_comb begin
    w_any     = 1'b0;
    w_win_idx = '0;
    w_scan    = '0;
    w_grant   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_scan = {1'b0, ptr_q} + (c_PTR_W + 1)'(k);
      if (w_scan >= c_NREQ) begin
        w_scan = w_scan - c_NREQ;
      end
      if (!w_any && req_valid_i[w_scan[c_PTR_W-1:0]]) begin
        w_any     = 1'b1;
        w_win_idx = w_scan[c_PTR_W-1:0];
      end
    end
    if (w_any) begin
      w_grant[w_win_idx] = 1'b1;
    end
  end

  assign req_ready_o = w_grant;

  // Winner's address/data mux with constant slice bases.
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (k == int'(w_win_idx)) begin
        w_sel_addr = req_addr_i[k*ADDR_W +: ADDR_W];
        w_sel_data = req_data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  // The address and data hold when nothing transfers, and only the strobe drops.
  always_comb begin
    we_d    = w_any;
    waddr_d = w_any ? w_sel_addr : waddr_q;
    wdata_d = w_any ? w_sel_data : wdata_q;
    ptr_d   = ptr_q;
    if (w_any) begin
      ptr_d = (w_win_idx == c_LAST) ? '0 : w_win_idx + 1'b1;
    end
    err_ovf_d = err_ovf_q | (|w_ovf);
    err_unf_d = err_unf_q | (|w_unf);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q     <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
    end
  end

  assign write_enable_o  = we_q;
  assign write_addr_o    = waddr_q;
  assign write_data_o    = wdata_q;
  assign err_overflow_o  = err_ovf_q;
  assign err_underflow_o = err_unf_q;

  // Pending-write scoreboard. A retire is taken from the output stage, so it
  // counts the write that the register file is accepting this cycle.
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_sb
    logic             w_claim;
    logic             w_retire;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign w_claim  = claim_valid_i && (claim_addr_i == ADDR_W'(r));
    assign w_retire = we_q && (waddr_q == ADDR_W'(r));

    // Flush suppresses the error flags along with the count change.
    assign w_ovf[r] = !flush_i && w_claim && !w_retire && (cnt_q == c_CNT_MAX);
    assign w_unf[r] = !flush_i && w_retire && !w_claim && (cnt_q == '0);

    always_comb begin
      cnt_d = cnt_q;
      if (flush_i) begin
        cnt_d = '0;
      end else if (w_claim && !w_retire) begin
        if (cnt_q != c_CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if (w_retire && !w_claim) begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign busy_o[r] = (cnt_q != '0);
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Directed bench for regfile_wb_arbiter. Expected register-file
//            writes are queued as each stimulus is issued. A monitor pops
//            and compares them whenever the write strobe is high.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [8:0]  req_addr;
  logic [47:0] req_data;
  logic        write_enable;
  logic [2:0]  write_addr;
  logic [15:0] write_data;
  logic        claim_valid;
  logic [2:0]  claim_addr;
  logic        flush;
  logic [7:0]  busy;
  logic        err_overflow;
  logic        err_underflow;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [18:0] exp_q[$];
  logic [18:0] mon_e;

  regfile_wb_arbiter dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_addr_i     (req_addr),
    .req_data_i     (req_data),
    .write_enable_o (write_enable),
    .write_addr_o   (write_addr),
    .write_data_o   (write_data),
    .claim_valid_i  (claim_valid),
    .claim_addr_i   (claim_addr),
    .flush_i        (flush),
    .busy_o         (busy),
    .err_overflow_o (err_overflow),
    .err_underflow_o(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge. Outputs are sampled there
  // or at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    req_valid   = '0;
    req_addr    = '0;
    req_data    = '0;
    claim_valid = 1'b0;
    claim_addr  = '0;
    flush       = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic do_write(input int i, input logic [2:0] a, input logic [15:0] d);
    req_valid          = 3'b000;
    req_valid[i]       = 1'b1;
    req_addr[i*3 +: 3] = a;
    req_data[i*16 +: 16] = d;
    exp_q.push_back({a, d});
    tick();
    req_valid = 3'b000;
  endtask

  task automatic claim(input logic [2:0] a);
    claim_valid = 1'b1;
    claim_addr  = a;
    tick();
    claim_valid = 1'b0;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && write_enable) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL wb_unexpected: got addr=%0d data=%h, required no write", write_addr, write_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wb_addr", 32'(write_addr), 32'(mon_e[18:16]));
        chk("wb_data", 32'(write_data), 32'(mon_e[15:0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  logic [2:0]  exp_c_addr [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
  logic [15:0] exp_c_data [6] = '{16'hA000, 16'hA010, 16'hA020, 16'hA001, 16'hA011, 16'hA021};
  logic [2:0]  exp_c_rdy  [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

  initial begin
    int   g [3];
    logic [2:0] rdy;

    // Reset and idle.
    do_reset();
    chk("reset_we", 32'(write_enable), 32'd0);
    chk("reset_busy", 32'(busy), 32'h00);
    chk("reset_ovf", 32'(err_overflow), 32'd0);
    chk("reset_unf", 32'(err_underflow), 32'd0);

    // Single request from requester 1.
    req_valid = 3'b010;
    req_addr[3 +: 3] = 3'd3;
    req_data[16 +: 16] = 16'hBEEF;
    #1;
    chk("single_ready", 32'(req_ready), 32'b010);
    exp_q.push_back({3'd3, 16'hBEEF});
    tick();
    req_valid = 3'b000;
    chk("single_we_hi", 32'(write_enable), 32'd1);
    tick();
    chk("single_we_lo", 32'(write_enable), 32'd0);
    chk("single_unclaimed_unf", 32'(err_underflow), 32'd1);

    // Asynchronous reset while a write sits in the output stage.
    req_valid = 3'b001;
    req_addr[0 +: 3] = 3'd2;
    req_data[0 +: 16] = 16'h1234;
    tick();
    req_valid = 3'b000;
    rst_n = 1'b0;
    #1;
    chk("async_rst_we", 32'(write_enable), 32'd0);
    chk("async_rst_unf", 32'(err_underflow), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // All three requesters valid: grants 0,1,2,0,1,2, back-to-back writes.
    do_reset();
    g = '{0, 0, 0};
    for (int k = 0; k < 6; k++) begin
      req_valid = 3'b111;
      for (int i = 0; i < 3; i++) begin
        req_addr[i*3 +: 3]   = 3'(1 + i + 3*g[i]);
        req_data[i*16 +: 16] = 16'hA000 + 16'(16*i + g[i]);
      end
      #1;
      rdy = req_ready;
      chk("rr_ready", 32'(rdy), 32'(exp_c_rdy[k]));
      exp_q.push_back({exp_c_addr[k], exp_c_data[k]});
      tick();
      for (int i = 0; i < 3; i++) begin
        if (rdy[i]) g[i]++;
      end
      chk("rr_we_stream", 32'(write_enable), 32'd1);
    end
    req_valid = 3'b000;
    tick();
    chk("rr_we_end", 32'(write_enable), 32'd0);

    // Claim r5 twice, retire twice.
    do_reset();
    claim(3'd5);
    claim(3'd5);
    chk("busy5_claimed", 32'(busy[5]), 32'd1);
    do_write(0, 3'd5, 16'h5555);
    tick();
    chk("busy5_one_left", 32'(busy[5]), 32'd1);
    do_write(0, 3'd5, 16'h5556);
    tick();
    chk("busy5_clear", 32'(busy[5]), 32'd0);
    chk("busy5_no_unf", 32'(err_underflow), 32'd0);

    // Same-cycle claim and retire of r2 leaves its count at 1.
    claim(3'd2);
    do_write(0, 3'd2, 16'h2222);
    claim(3'd2);
    chk("busy2_same_cycle", 32'(busy[2]), 32'd1);
    do_write(0, 3'd2, 16'h2223);
    tick();
    chk("busy2_clear", 32'(busy[2]), 32'd0);
    chk("busy2_no_unf", 32'(err_underflow), 32'd0);

    // Four claims on r7 saturate the counter at 3.
    claim(3'd7);
    claim(3'd7);
    claim(3'd7);
    chk("ovf_before", 32'(err_overflow), 32'd0);
    claim(3'd7);
    chk("ovf_after", 32'(err_overflow), 32'd1);
    chk("busy7_sat", 32'(busy[7]), 32'd1);
    do_write(1, 3'd7, 16'h7771);
    do_write(1, 3'd7, 16'h7772);
    do_write(1, 3'd7, 16'h7773);
    tick();
    chk("busy7_drained", 32'(busy[7]), 32'd0);
    chk("busy7_no_unf", 32'(err_underflow), 32'd0);

    // Flush overrides a concurrent claim. A later unclaimed write underflows.
    do_reset();
    claim(3'd1);
    claim(3'd4);
    chk("pre_flush_busy", 32'(busy), 32'h12);
    flush       = 1'b1;
    claim_valid = 1'b1;
    claim_addr  = 3'd6;
    tick();
    flush       = 1'b0;
    claim_valid = 1'b0;
    chk("flush_busy", 32'(busy), 32'h00);
    chk("flush_ovf", 32'(err_overflow), 32'd0);
    chk("flush_unf", 32'(err_underflow), 32'd0);
    do_write(2, 3'd1, 16'h1111);
    tick();
    chk("post_flush_unf", 32'(err_underflow), 32'd1);

    repeat (3) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port among NUM_REQ writeback requesters (e.g. ALU writeback, memory-load return, input port) using round-robin arbitration and a valid/ready handshake.
- Drives the registered write_enable/write_addr/write_data triple straight into the register file.
- Keeps a per-register pending-write scoreboard so decode can stall on registers with outstanding writes.

Parameters:
- DATA_W, 16, register data width
- ADDR_W, 3, register address width
- NUM_REGS, 8, register count (2**ADDR_W)
- NUM_REQ, 3, number of writeback requesters
- CNT_W, 2, width of the per-register pending counter

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous active-low reset (0 = reset asserted)
- req_valid  input  NUM_REQ  requester i has a write pending
- req_ready  output  NUM_REQ  requester i granted this cycle
- req_addr  input  NUM_REQ*ADDR_W  destination register, requester i at bits [i*ADDR_W +: ADDR_W]
- req_data  input  NUM_REQ*DATA_W  write data, requester i at bits [i*DATA_W +: DATA_W]
- write_enable  output  1  register-file write strobe (registered)
- write_addr  output  ADDR_W  register-file write address (registered)
- write_data  output  DATA_W  register-file write data (registered)
- claim_valid  input  1  decode issues an instruction that will write claim_addr
- claim_addr  input  ADDR_W  destination being claimed
- flush  input  1  synchronous scoreboard clear (pipeline flush)
- busy  output  NUM_REGS  bit r = register r has at least one outstanding write
- err_overflow  output  1  sticky: claim issued on a saturated counter
- err_underflow  output  1  sticky: retire issued on a zero counter

Behaviour:
- Reset (rst=0, asynchronous) clears the following, including a write in flight, which is dropped:
  - write_enable, write_addr, write_data all 0
  - all pending counters 0, so busy = 0
  - err_overflow = 0 and err_underflow = 0
  - round-robin pointer = 0
- Arbitration is combinational on req_valid and the pointer:
  - Exactly one req_ready is high when any req_valid is high; none otherwise.
  - The winner is the first valid requester scanning pointer, pointer+1, … modulo NUM_REQ.
  - req_ready never asserts without the matching req_valid.
- Transfer happens when req_valid[i] & req_ready[i]. On that edge:
  - write_enable <= 1, write_addr <= req_addr[i], write_data <= req_data[i]
  - pointer <= (i+1) mod NUM_REQ
- With no transfer, write_enable <= 0 next edge. write_addr and write_data hold their previous values.
- Latency: accepted at edge N, write visible on the register-file port during cycle N+1. Sustained throughput is one write per cycle.
- Requester rule: req_addr and req_data stay stable while valid and not yet ready. Dropping valid before acceptance is legal (request withdrawn).
- Scoreboard:
  - A retire event of register r occurs in any cycle where write_enable=1 and write_addr=r (the output stage).
  - claim_valid at claim_addr=r increments cnt[r].
  - Claim and retire of the same r in the same cycle leave cnt[r] unchanged.
  - Claim when cnt[r] = 2**CNT_W-1: counter holds and err_overflow is set.
  - Retire when cnt[r] = 0: counter holds at 0 and err_underflow is set. This covers writes that were never claimed.
  - busy[r] = (cnt[r] != 0), combinational from registered counters, so busy updates one cycle after the claim or retire edge.
  - flush=1: all counters <= 0 next edge. Flush overrides a claim or retire in the same cycle and does not raise error flags.
  - Flush does not affect arbitration, the output register or the sticky errors. Only rst clears the errors.
- Arbitration does not consult the scoreboard. Two requesters writing the same register are serialized in grant order, and the last grant wins in the register file.

Test Plan:
- Reset then idle → write_enable=0, busy=0x00, both error flags 0; assert rst=0 mid-transfer → write_enable drops to 0 immediately.
- Single request: requester 1 valid, addr 3, data 0xBEEF → req_ready=3'b010 same cycle; next cycle write_enable=1, write_addr=3, write_data=0xBEEF; following cycle write_enable=0.
- All three requesters valid continuously, after reset → grants in order 0,1,2,0,1,2; six consecutive cycles with write_enable=1; each write carries its own addr/data.
- Claim r5 twice (cnt=2, busy[5]=1), then retire r5 once → busy[5] still 1; second retire → busy[5]=0 one cycle later.
- Same-cycle claim of r2 and retire of r2 with cnt[2]=1 → cnt stays 1, busy[2] stays 1; four claims to r7 with no retires → fourth raises err_overflow, cnt[7]=3.
- Claims on r1, r4, then flush together with a claim on r6 → busy=0x00 next cycle, no errors; a later write to r1 → err_underflow=1.
